ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 5-bit register index.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for HI/LO and mult/div state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 read_data1  input  32  rs operand from the ID/EX register.
REQ-005 read_data2  input  32  rt operand from the ID/EX register.
REQ-006 extended_bits  input  32  sign-extended immediate; [5:0] is funct, [10:6] is shamt.
REQ-007 new_pc_value  input  32  PC+4 of the instruction.
REQ-008 instr_bits_15_11, instr_bits_20_16  input  5 each  rd and rt indices.
REQ-009 RegDst, ALUSrc, Branch  input  1 each  decoded controls.
REQ-010 ALUOp  input  3  ALU class.
REQ-011 alu_result  output  32  ALU, shift, or mfhi/mflo result.
REQ-012 zero  output  1  high when alu_result equals 0.
REQ-013 branch_target  output  32  new_pc_value + (extended_bits << 2).
REQ-014 write_reg  output  5  instr_bits_15_11 when RegDst, else instr_bits_20_16.
REQ-015 store_data  output  32  read_data2 unchanged.
REQ-016 stall  output  1  freezes PC, IF/ID and ID/EX while high.
REQ-017 hi_value, lo_value  output  32 each  HI/LO register contents.

Function
REQ-018 ALU operand B SHALL be extended_bits when ALUSrc is high, else read_data2; operand A SHALL be read_data1.
REQ-019 ALUOp SHALL decode as follows: 000 add; 001 sub; 010 R-type by funct; 011 and; 100 or; 101 signed slt; 110 lui (B<<16); 111 add.
REQ-020 R-type funct SHALL decode as follows: 20/21 add; 22/23 sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt; 2B sltu; 00 sll; 02 srl; 03 sra (shift rt by shamt); 10 mfhi; 12 mflo; others give 0.
REQ-021 Add and sub SHALL wrap modulo 2^32; no overflow flag is produced.
REQ-022 alu_result, zero, branch_target, write_reg and store_data SHALL be combinational, with zero cycles of latency.
REQ-023 R-type funct 18/19/1A/1B (mult, multu, div, divu) SHALL be handled by an iterative mult/div FSM with states IDLE, BUSY and DONE.
REQ-024 In IDLE with a mult/div op present, the FSM SHALL latch the operands, load a 6-bit counter with 32, assert stall, and go to BUSY.
REQ-025 In BUSY, the FSM SHALL perform one shift-add or one restoring-subtract step per cycle, keep stall asserted, and decrement the counter.
REQ-026 When the counter reaches 0, the FSM SHALL write HI/LO and go to DONE.
REQ-027 In DONE, stall SHALL be low and no new op SHALL be accepted; the FSM SHALL return to IDLE on the next edge.
REQ-028 A mult/div op SHALL occupy 34 cycles in total: 33 with stall high and 1 in DONE.
REQ-029 mult SHALL produce the signed 64-bit product in {HI,LO}, and multu the unsigned product.
REQ-030 div SHALL put the quotient in LO and the remainder in HI.
REQ-031 Signed ops SHALL use magnitudes; the quotient sign is the XOR of the operand signs and the remainder sign is the dividend sign.
REQ-032 Divide by zero SHALL give LO=FFFFFFFF and HI=dividend; the unsigned result is then sign-fixed as for any signed op, with no exception.
REQ-033 While stall is high, alu_result for mfhi/mflo SHALL reflect the current HI/LO; upstream freezing guarantees that no mfhi/mflo is consumed mid-operation.
REQ-034 mfhi/mflo in the cycle after DONE SHALL return the new HI/LO values.

Reset
REQ-035 Reset SHALL force the FSM to IDLE, stall to 0, the counter to 0, and hi_value and lo_value to 0.
REQ-036 Reset asserted mid-operation SHALL abort the operation, leaving HI/LO at 0; no partial result is committed.
REQ-037 Combinational outputs SHALL be unaffected by reset.

Structure
REQ-038 ALUOp codes, funct codes and FSM state encodings SHALL live in a shared package (mips_pkg) used by the decoder and ex_stage.
REQ-039 The mult/div datapath and FSM SHALL be one sub-module, mult_div_unit, with ports clk, reset, start, op[1:0], a, b, busy, hi, lo.
REQ-040 The ALU and the mux logic SHALL stay in ex_stage.

Verification
REQ-041 ALUOp=010, funct=22, rs=5, rt=7 -> alu_result=FFFFFFFE, zero=0.
REQ-042 ALUOp=001, rs=rt=0x1234, new_pc_value=0x100, imm=0xFFFFFFFC -> zero=1, branch_target=0xF0.
REQ-043 mult with rs=-3, rt=7 -> stall high for 33 cycles, then {HI,LO}=FFFFFFFF_FFFFFFEB; the following mflo returns FFFFFFEB.
REQ-044 div with rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-045 divu with rs=10, rt=0 -> LO=FFFFFFFF, HI=0000000A.
REQ-046 Reset pulsed at BUSY cycle 10 of a multu -> the next cycle shows stall=0, HI=LO=0, FSM in IDLE; a re-issued multu 3×4 then gives LO=12.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op classes, R-type funct codes and mult/div FSM states
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110,
        ALU_ADD2  = 3'b111
    } alu_op_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    // mult, multu, div, divu occupy funct 0x18..0x1B; funct[1:0] then selects the op
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step shift-add multiplier / restoring divider owning HI/LO
module mult_div_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_e   r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_p;
    logic [31:0] r_m;
    logic        r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [63:0] w_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // op[0] marks the unsigned variants; signed ops work on magnitudes
    assign w_sa    = !op[0] && a[31];
    assign w_sb    = !op[0] && b[31];
    assign w_abs_a = w_sa ? -a : a;
    assign w_abs_b = w_sb ? -b : b;

    // r_p holds {acc, multiplier} for mult and {remainder, dividend/quotient} for div
    assign w_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_m} : 33'd0);
    assign w_diff = r_p[63:31] - {1'b0, r_m};
    assign w_next = r_div ? (w_diff[32] ? {r_p[62:0], 1'b0} : {w_diff[31:0], r_p[30:0], 1'b1})
                          : {w_sum, r_p[31:1]};
    assign w_prod = r_neg_q ? -w_next : w_next;
    assign w_quo  = r_neg_q ? -w_next[31:0] : w_next[31:0];
    assign w_rem  = r_neg_r ? -w_next[63:32] : w_next[63:32];

    // stall must rise in the very cycle the op is presented so the pipeline holds it
    assign busy = (r_state == MD_IDLE && start) || r_state == MD_BUSY;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // mult/div sequencer: latch operands, 32 iterative steps, commit HI/LO, one DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= 6'd0;
            r_p     <= 64'd0;
            r_m     <= 32'd0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: if (start) begin
                    r_m     <= op[1] ? w_abs_b : w_abs_a;
                    r_p     <= {32'd0, op[1] ? w_abs_a : w_abs_b};
                    r_div   <= op[1];
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_cnt   <= 6'd32;
                    r_state <= MD_BUSY;
                end
                MD_BUSY: begin
                    r_p   <= w_next;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_hi    <= r_div ? w_rem : w_prod[63:32];
                        r_lo    <= r_div ? w_quo : w_prod[31:0];
                        r_state <= MD_DONE;
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - ALU, operand/destination muxes, branch target, HI/LO via mult_div_unit
module ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] extended_bits,
    input  logic [31:0] new_pc_value,
    input  logic [4:0]  instr_bits_15_11,
    input  logic [4:0]  instr_bits_20_16,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        Branch,
    input  logic [2:0]  ALUOp,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] branch_target,
    output logic [4:0]  write_reg,
    output logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] hi_value,
    output logic [31:0] lo_value
);
    logic [31:0] w_b;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic        w_md_start;
    logic        w_unused;

    assign w_b           = ALUSrc ? extended_bits : read_data2;
    assign w_funct       = extended_bits[5:0];
    assign w_shamt       = extended_bits[10:6];
    assign w_md_start    = (ALUOp == ALU_RTYPE) && is_muldiv(w_funct);
    assign zero          = alu_result == 32'd0;
    assign branch_target = new_pc_value + {extended_bits[29:0], 2'b00};
    assign write_reg     = RegDst ? instr_bits_15_11 : instr_bits_20_16;
    assign store_data    = read_data2;
    // the branch decision is resolved downstream from zero
    assign w_unused      = Branch;

    mult_div_unit u_md (
        .clk   (clk),
        .reset (reset),
        .start (w_md_start),
        .op    (w_funct[1:0]),
        .a     (read_data1),
        .b     (read_data2),
        .busy  (stall),
        .hi    (hi_value),
        .lo    (lo_value)
    );

    // ALU: class from ALUOp, R-type refined by funct; shifts always act on rt
    always_comb begin
        alu_result = 32'd0;
        case (ALUOp)
            ALU_ADD, ALU_ADD2: alu_result = read_data1 + w_b;
            ALU_SUB:           alu_result = read_data1 - w_b;
            ALU_AND:           alu_result = read_data1 & w_b;
            ALU_OR:            alu_result = read_data1 | w_b;
            ALU_SLT:           alu_result = {31'd0, $signed(read_data1) < $signed(w_b)};
            ALU_LUI:           alu_result = w_b << 16;
            ALU_RTYPE: case (w_funct)
                F_ADD, F_ADDU: alu_result = read_data1 + w_b;
                F_SUB, F_SUBU: alu_result = read_data1 - w_b;
                F_AND:         alu_result = read_data1 & w_b;
                F_OR:          alu_result = read_data1 | w_b;
                F_XOR:         alu_result = read_data1 ^ w_b;
                F_NOR:         alu_result = ~(read_data1 | w_b);
                F_SLT:         alu_result = {31'd0, $signed(read_data1) < $signed(w_b)};
                F_SLTU:        alu_result = {31'd0, read_data1 < w_b};
                F_SLL:         alu_result = read_data2 << w_shamt;
                F_SRL:         alu_result = read_data2 >> w_shamt;
                F_SRA:         alu_result = $signed(read_data2) >>> w_shamt;
                F_MFHI:        alu_result = hi_value;
                F_MFLO:        alu_result = lo_value;
                default:       alu_result = 32'd0;
            endcase
            default:           alu_result = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage ALU paths and mult/div sequencing
module tb_ex_stage;
    logic        clk;
    logic        reset;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] extended_bits;
    logic [31:0] new_pc_value;
    logic [4:0]  instr_bits_15_11;
    logic [4:0]  instr_bits_20_16;
    logic        RegDst;
    logic        ALUSrc;
    logic        Branch;
    logic [2:0]  ALUOp;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_target;
    logic [4:0]  write_reg;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] hi_value;
    logic [31:0] lo_value;

    int tests = 0;
    int fails = 0;
    int cycles;

    ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .read_data1       (read_data1),
        .read_data2       (read_data2),
        .extended_bits    (extended_bits),
        .new_pc_value     (new_pc_value),
        .instr_bits_15_11 (instr_bits_15_11),
        .instr_bits_20_16 (instr_bits_20_16),
        .RegDst           (RegDst),
        .ALUSrc           (ALUSrc),
        .Branch           (Branch),
        .ALUOp            (ALUOp),
        .alu_result       (alu_result),
        .zero             (zero),
        .branch_target    (branch_target),
        .write_reg        (write_reg),
        .store_data       (store_data),
        .stall            (stall),
        .hi_value         (hi_value),
        .lo_value         (lo_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [2:0] op, input logic src, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        ALUOp         = op;
        ALUSrc        = src;
        read_data1    = a;
        read_data2    = b;
        extended_bits = imm;
        #1;
    endtask

    // present a mult/div op, count edges while stall stays high, then issue mflo
    task automatic run_md(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b, output int n);
        alu(3'b010, 1'b0, a, b, {26'd0, funct});
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        extended_bits = 32'h12;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        read_data1 = 0; read_data2 = 0; extended_bits = 0; new_pc_value = 0;
        instr_bits_15_11 = 0; instr_bits_20_16 = 0;
        RegDst = 0; ALUSrc = 0; Branch = 0; ALUOp = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_hi", {32'd0, hi_value}, 64'd0);
        check("reset_lo", {32'd0, lo_value}, 64'd0);
        reset = 1'b0;

        alu(3'b010, 1'b0, 32'd5, 32'd7, 32'h22);
        check("sub_rtype", {32'd0, alu_result}, 64'hFFFFFFFE);
        check("sub_rtype_zero", {63'd0, zero}, 64'd0);

        new_pc_value = 32'h100;
        alu(3'b001, 1'b0, 32'h1234, 32'h1234, 32'hFFFFFFFC);
        check("beq_zero", {63'd0, zero}, 64'd1);
        check("beq_target", {32'd0, branch_target}, 64'hF0);

        alu(3'b000, 1'b1, 32'd16, 32'd0, 32'hFFFFFFFF);
        check("addi_neg", {32'd0, alu_result}, 64'hF);
        alu(3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        check("add_wrap", {32'd0, alu_result}, 64'd0);
        check("add_wrap_zero", {63'd0, zero}, 64'd1);
        alu(3'b011, 1'b0, 32'hF0F0, 32'hFF00, 32'd0);
        check("and", {32'd0, alu_result}, 64'hF000);
        alu(3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'd0);
        check("or", {32'd0, alu_result}, 64'hFFF0);
        alu(3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        check("slt_signed", {32'd0, alu_result}, 64'd1);
        alu(3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h2B);
        check("sltu", {32'd0, alu_result}, 64'd0);
        alu(3'b110, 1'b1, 32'd0, 32'd0, 32'h1234);
        check("lui", {32'd0, alu_result}, 64'h12340000);
        alu(3'b010, 1'b0, 32'd0, 32'h80000000, 32'h103);
        check("sra", {32'd0, alu_result}, 64'hF8000000);
        alu(3'b010, 1'b0, 32'd0, 32'h80000000, 32'h102);
        check("srl", {32'd0, alu_result}, 64'h08000000);
        alu(3'b010, 1'b0, 32'd0, 32'd1, 32'h100);
        check("sll", {32'd0, alu_result}, 64'h10);
        alu(3'b010, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h26);
        check("xor", {32'd0, alu_result}, 64'hF00FF00F);
        alu(3'b010, 1'b0, 32'd0, 32'd0, 32'h27);
        check("nor", {32'd0, alu_result}, 64'hFFFFFFFF);
        alu(3'b010, 1'b0, 32'd9, 32'd9, 32'h3F);
        check("bad_funct", {32'd0, alu_result}, 64'd0);
        check("store_data", {32'd0, store_data}, 64'd9);
        instr_bits_15_11 = 5'h1F; instr_bits_20_16 = 5'h03; RegDst = 1'b1;
        #1;
        check("write_reg_rd", {59'd0, write_reg}, 64'h1F);
        RegDst = 1'b0;
        #1;
        check("write_reg_rt", {59'd0, write_reg}, 64'h03);

        run_md(6'h18, 32'hFFFFFFFD, 32'd7, cycles);
        check("mult_stall_cycles", 64'(cycles), 64'd33);
        check("mult_hilo", {hi_value, lo_value}, 64'hFFFFFFFF_FFFFFFEB);
        check("mflo_after", {32'd0, alu_result}, 64'hFFFFFFEB);
        extended_bits = 32'h10;
        #1;
        check("mfhi_after", {32'd0, alu_result}, 64'hFFFFFFFF);

        run_md(6'h1A, 32'hFFFFFFF9, 32'd2, cycles);
        check("div_stall_cycles", 64'(cycles), 64'd33);
        check("div_hilo", {hi_value, lo_value}, 64'hFFFFFFFF_FFFFFFFD);

        run_md(6'h1B, 32'd10, 32'd0, cycles);
        check("divu_by_zero", {hi_value, lo_value}, 64'h0000000A_FFFFFFFF);

        run_md(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, cycles);
        check("multu_max", {hi_value, lo_value}, 64'hFFFFFFFE_00000001);

        alu(3'b010, 1'b0, 32'd5, 32'd6, 32'h19);
        check("multu_stall_start", {63'd0, stall}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        extended_bits = 32'h20;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_stall", {63'd0, stall}, 64'd0);
        check("abort_hilo", {hi_value, lo_value}, 64'd0);

        run_md(6'h19, 32'd3, 32'd4, cycles);
        check("reissue_cycles", 64'(cycles), 64'd33);
        check("reissue_hilo", {hi_value, lo_value}, 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
